// File: rtl/fcpu_rob.sv
// Reorder buffer: in-order allocate, CDB result capture, in-order commit.
// Optional macro FCPU_ROB_BYPASS_EN forwards a CDB hit on the head entry straight to commit.
module fcpu_rob #(
  parameter int N_ROB_W    = 4,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int RSV_ID_W   = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [2:0]                   alloc_type,
  input  logic [REG_ADDR_W-1:0]        alloc_dst_reg,
  output logic [N_ROB_W-1:0]           alloc_tag,
  input  logic                         cdb_valid,
  input  logic [RSV_ID_W+DATA_W-1:0]   cdb,
  output logic                         commit_valid,
  input  logic                         commit_ready,
  output logic [2:0]                   commit_type,
  output logic [REG_ADDR_W-1:0]        commit_dst_reg,
  output logic [DATA_W-1:0]            commit_data,
  output logic [N_ROB_W-1:0]           commit_tag,
  output logic [N_ROB_W:0]             count,
  output logic                         empty
);
  localparam int N = 1 << N_ROB_W;

  logic [N_ROB_W:0]      head_q, head_d, tail_q, tail_d;
  logic                  valid_q [N];
  logic                  valid_d [N];
  logic                  done_q  [N];
  logic                  done_d  [N];
  logic [2:0]            type_q  [N];
  logic [2:0]            type_d  [N];
  logic [REG_ADDR_W-1:0] dst_q   [N];
  logic [REG_ADDR_W-1:0] dst_d   [N];
  logic [DATA_W-1:0]     data_q  [N];
  logic [DATA_W-1:0]     data_d  [N];

  logic [N_ROB_W-1:0] head_idx, tail_idx, cdb_idx;
  logic [DATA_W-1:0]  cdb_data;
  logic               full, bypass_hit, alloc_fire, cdb_fire, commit_fire;

  assign head_idx = head_q[N_ROB_W-1:0];
  assign tail_idx = tail_q[N_ROB_W-1:0];
  assign cdb_idx  = cdb[DATA_W +: N_ROB_W];
  assign cdb_data = cdb[DATA_W-1:0];

  // Tag bits above the entry index carry no meaning inside the buffer.
  generate
    if (RSV_ID_W > N_ROB_W) begin : g_tag_hi
      logic [RSV_ID_W-N_ROB_W-1:0] cdb_tag_unused;
      assign cdb_tag_unused = cdb[RSV_ID_W+DATA_W-1:N_ROB_W+DATA_W];
    end
  endgenerate

  assign full = (head_idx == tail_idx) && (head_q[N_ROB_W] != tail_q[N_ROB_W]);

`ifdef FCPU_ROB_BYPASS_EN
  assign bypass_hit = cdb_valid && !flush && (cdb_idx == head_idx) &&
                      valid_q[head_idx] && !done_q[head_idx];
`else
  assign bypass_hit = 1'b0;
`endif

  assign commit_valid   = valid_q[head_idx] && (done_q[head_idx] || bypass_hit);
  assign commit_data    = bypass_hit ? cdb_data : data_q[head_idx];
  assign commit_type    = type_q[head_idx];
  assign commit_dst_reg = dst_q[head_idx];
  assign commit_tag     = head_idx;

  assign alloc_ready = !full;
  assign alloc_tag   = tail_idx;
  assign count       = tail_q - head_q;
  assign empty       = (head_q == tail_q);

  assign alloc_fire  = alloc_valid && !full && !flush;
  assign cdb_fire    = cdb_valid && !flush && valid_q[cdb_idx] && !done_q[cdb_idx];
  assign commit_fire = commit_valid && commit_ready && !flush;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (commit_fire) head_d = head_q + 1'b1;
      if (alloc_fire)  tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      always_comb begin
        valid_d[gi] = valid_q[gi];
        done_d[gi]  = done_q[gi];
        type_d[gi]  = type_q[gi];
        dst_d[gi]   = dst_q[gi];
        data_d[gi]  = data_q[gi];
        if (flush) begin
          valid_d[gi] = 1'b0;
          done_d[gi]  = 1'b0;
        end else if (alloc_fire && (tail_idx == N_ROB_W'(gi))) begin
          valid_d[gi] = 1'b1;
          done_d[gi]  = 1'b0;
          type_d[gi]  = alloc_type;
          dst_d[gi]   = alloc_dst_reg;
          data_d[gi]  = '0;
        end else begin
          if (cdb_fire && (cdb_idx == N_ROB_W'(gi))) begin
            done_d[gi] = 1'b1;
            data_d[gi] = cdb_data;
          end
          // A bypassed commit also lands here; clearing done keeps the slot clean.
          if (commit_fire && (head_idx == N_ROB_W'(gi))) begin
            valid_d[gi] = 1'b0;
            done_d[gi]  = 1'b0;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q[gi] <= 1'b0;
          done_q[gi]  <= 1'b0;
          type_q[gi]  <= '0;
          dst_q[gi]   <= '0;
          data_q[gi]  <= '0;
        end else begin
          valid_q[gi] <= valid_d[gi];
          done_q[gi]  <= done_d[gi];
          type_q[gi]  <= type_d[gi];
          dst_q[gi]   <= dst_d[gi];
          data_q[gi]  <= data_d[gi];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fcpu_rob.sv
// Directed bench for fcpu_rob: vector table plus reset, full, flush and wrap sequences.
module tb_fcpu_rob;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [2:0]  alloc_type = '0;
  logic [4:0]  alloc_dst_reg = '0;
  logic [3:0]  alloc_tag;
  logic        cdb_valid = 1'b0;
  logic [36:0] cdb = '0;
  logic        commit_valid;
  logic        commit_ready = 1'b0;
  logic [2:0]  commit_type;
  logic [4:0]  commit_dst_reg;
  logic [31:0] commit_data;
  logic [3:0]  commit_tag;
  logic [4:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_errors = 0;
`ifdef FCPU_ROB_BYPASS_EN
  bit byp = 1'b1;
`else
  bit byp = 1'b0;
`endif

  always #5 clk = ~clk;

  fcpu_rob dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_type(alloc_type),
    .alloc_dst_reg(alloc_dst_reg), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb(cdb),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_type(commit_type),
    .commit_dst_reg(commit_dst_reg), .commit_data(commit_data), .commit_tag(commit_tag),
    .count(count), .empty(empty)
  );

  typedef struct {
    logic        fl, av;
    logic [2:0]  at;
    logic [4:0]  ad;
    logic        cv;
    logic [4:0]  ct;
    logic [31:0] cd;
    logic        cr;
    logic        e_ar;
    logic [3:0]  e_atag;
    logic        e_cv;
    logic [2:0]  e_ctype;
    logic [4:0]  e_cdst;
    logic [31:0] e_cdata;
    logic [3:0]  e_ctag;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(logic av, logic [2:0] at, logic [4:0] ad, logic cv,
                              logic [4:0] ct, logic [31:0] cd, logic cr, logic [3:0] e_atag,
                              logic e_cv, logic [2:0] e_ctype, logic [4:0] e_cdst,
                              logic [31:0] e_cdata, logic [3:0] e_ctag, logic [4:0] e_cnt);
    vec_t v;
    v.fl = 1'b0; v.av = av; v.at = at; v.ad = ad; v.cv = cv; v.ct = ct; v.cd = cd; v.cr = cr;
    v.e_ar = 1'b1; v.e_atag = e_atag; v.e_cv = e_cv; v.e_ctype = e_ctype; v.e_cdst = e_cdst;
    v.e_cdata = e_cdata; v.e_ctag = e_ctag; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic av, input logic [2:0] at, input logic [4:0] ad,
                       input logic cv, input logic [4:0] ct, input logic [31:0] cd, input logic cr);
    flush = fl; alloc_valid = av; alloc_type = at; alloc_dst_reg = ad;
    cdb_valid = cv; cdb = {ct, cd}; commit_ready = cr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wrap test model state
  bit          m_done [16];
  logic [31:0] m_dat  [16];
  int          m_head, m_tail, m_cnt, seq;

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0,     0,     0, 0, 0,   0, 0, 0,                  0, 0);
    vecs[1]  = mk(1, 1, 3, 0, 0,     0,     0, 0, 0,   0, 0, 0,                  0, 0);
    vecs[2]  = mk(1, 1, 4, 0, 0,     0,     0, 1, 0,   1, 3, 0,                  0, 1);
    vecs[3]  = mk(1, 2, 5, 0, 0,     0,     0, 2, 0,   1, 3, 0,                  0, 2);
    vecs[4]  = mk(0, 0, 0, 1, 2,     'hC,   0, 3, 0,   1, 3, 0,                  0, 3);
    vecs[5]  = mk(0, 0, 0, 1, 0,     'hA,   0, 3, byp, 1, 3, byp ? 32'hA : 0,    0, 3);
    vecs[6]  = mk(0, 0, 0, 1, 1,     'hB,   1, 3, 1,   1, 3, 'hA,               0, 3);
    vecs[7]  = mk(0, 0, 0, 0, 0,     0,     1, 3, 1,   1, 4, 'hB,               1, 2);
    vecs[8]  = mk(0, 0, 0, 0, 0,     0,     1, 3, 1,   2, 5, 'hC,               2, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0,     0,     0, 3, 0,   0, 0, 0,                  3, 0);
    vecs[10] = mk(1, 3, 7, 0, 0,     0,     0, 3, 0,   0, 0, 0,                  3, 0);
    vecs[11] = mk(0, 0, 0, 1, 3,     'h33,  0, 4, byp, 3, 7, byp ? 32'h33 : 0,   3, 1);
    vecs[12] = mk(1, 4, 8, 0, 0,     0,     1, 4, 1,   3, 7, 'h33,              3, 1);
    vecs[13] = mk(0, 0, 0, 0, 0,     0,     0, 5, 0,   4, 8, 0,                  4, 1);
    vecs[14] = mk(0, 0, 0, 1, 7,     'h77,  0, 5, 0,   4, 8, 0,                  4, 1);
    vecs[15] = mk(0, 0, 0, 1, 5'h14, 'h44,  0, 5, byp, 4, 8, byp ? 32'h44 : 0,   4, 1);
    vecs[16] = mk(0, 0, 0, 1, 4,     'hFF,  0, 5, 1,   4, 8, 'h44,              4, 1);
    vecs[17] = mk(0, 0, 0, 0, 0,     0,     1, 5, 1,   4, 8, 'h44,              4, 1);
    vecs[18] = mk(0, 0, 0, 0, 0,     0,     0, 5, 0,   0, 0, 0,                  5, 0);

    // Reset state while rst is held
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_alloc_ready", 32'(alloc_ready), 1);
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_commit_fields", {commit_type, commit_dst_reg, commit_tag}, 0);
    chk("rst_commit_data", commit_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].av, vecs[i].at, vecs[i].ad, vecs[i].cv, vecs[i].ct,
            vecs[i].cd, vecs[i].cr);
      #1;
      chk($sformatf("v%0d_alloc_ready", i), 32'(alloc_ready), 32'(vecs[i].e_ar));
      chk($sformatf("v%0d_alloc_tag", i), 32'(alloc_tag), 32'(vecs[i].e_atag));
      chk($sformatf("v%0d_commit_valid", i), 32'(commit_valid), 32'(vecs[i].e_cv));
      chk($sformatf("v%0d_commit_type", i), 32'(commit_type), 32'(vecs[i].e_ctype));
      chk($sformatf("v%0d_commit_dst", i), 32'(commit_dst_reg), 32'(vecs[i].e_cdst));
      chk($sformatf("v%0d_commit_data", i), commit_data, vecs[i].e_cdata);
      chk($sformatf("v%0d_commit_tag", i), 32'(commit_tag), 32'(vecs[i].e_ctag));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_cnt == 0));
      $display("vec %0d: cv=%0b dst=%0d data=%0h count=%0d", i, commit_valid,
               commit_dst_reg, commit_data, count);
    end

    // Asynchronous reset in the middle of operation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(0, 1, 0, 5'(i), i == 4, 0, 32'h5A, 0);
    end
    @(negedge clk);
    idle();
    #1;
    chk("mid_count_before", 32'(count), 5);
    chk("mid_cv_before", 32'(commit_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_ready", 32'(alloc_ready), 1);
    chk("mid_rst_cv", 32'(commit_valid), 0);
    $display("mid-op reset: count=%0d empty=%0b cv=%0b", count, empty, commit_valid);
    @(negedge clk);
    rst = 1'b0;

    // Fill all 16 entries, then free one
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(0, 1, 3'(i), 5'(i), 0, 0, 0, 0);
      #1;
      chk($sformatf("full_fill%0d_tag", i), 32'(alloc_tag), 32'(i));
      chk($sformatf("full_fill%0d_ready", i), 32'(alloc_ready), 1);
    end
    @(negedge clk);
    drive(0, 1, 7, 31, 0, 0, 0, 0);
    #1;
    chk("full_ready", 32'(alloc_ready), 0);
    chk("full_count", 32'(count), 16);
    chk("full_tag", 32'(alloc_tag), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 32'h100, 0);
    #1;
    chk("full_17th_ignored", 32'(count), 16);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("full_commit_valid", 32'(commit_valid), 1);
    chk("full_commit_data", commit_data, 32'h100);
    chk("full_commit_dst", 32'(commit_dst_reg), 0);
    @(negedge clk);
    idle();
    #1;
    chk("full_after_ready", 32'(alloc_ready), 1);
    chk("full_after_tag", 32'(alloc_tag), 0);
    chk("full_after_count", 32'(count), 15);
    $display("full: after commit ready=%0b tag=%0d count=%0d", alloc_ready, alloc_tag, count);

    // Flush with 6 entries, 3 complete, and competing same-cycle requests
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(0, 1, 1, 5'(10 + i), 0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 5'(i), 32'(i + 1), 0);
    end
    @(negedge clk);
    drive(1, 1, 2, 20, 1, 3, 32'h5, 1);
    @(negedge clk);
    idle();
    #1;
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_cv", 32'(commit_valid), 0);
    chk("flush_tag", 32'(alloc_tag), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 2, 32'h99, 1);
    #1;
    chk("flush_stale_cv", 32'(commit_valid), 0);
    @(negedge clk);
    idle();
    #1;
    chk("flush_stale_count", 32'(count), 0);
    chk("flush_stale_cv2", 32'(commit_valid), 0);
    $display("flush: count=%0d cv=%0b tag=%0d", count, commit_valid, alloc_tag);

    // Wrap-around with random completion order and random commit_ready
    do_reset();
    m_head = 0; m_tail = 0; m_cnt = 0; seq = 0;
    for (int i = 0; i < 16; i++) begin
      m_done[i] = 1'b0;
      m_dat[i]  = '0;
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      int  idx, h;
      bit  exp_cv, do_alloc;
      @(negedge clk);
      idle();
      idx = 0;
      alloc_valid = ($urandom_range(0, 3) != 0);
      alloc_dst_reg = 5'(m_tail);
      if (m_cnt > 0 && $urandom_range(0, 1) == 1) begin
        idx = (m_head + int'($urandom_range(0, m_cnt - 1))) % 16;
        if (!m_done[idx]) begin
          cdb_valid = 1'b1;
          cdb = {5'(idx), m_dat[idx]};
        end
      end
      commit_ready = ($urandom_range(0, 1) == 1);
      #1;
      h = m_head % 16;
      exp_cv = (m_cnt > 0) && (m_done[h] || (byp && cdb_valid && idx == h));
      chk($sformatf("wrap%0d_cv", cyc), 32'(commit_valid), 32'(exp_cv));
      if (exp_cv) begin
        chk($sformatf("wrap%0d_data", cyc), commit_data, m_dat[h]);
        chk($sformatf("wrap%0d_tag", cyc), 32'(commit_tag), 32'(h));
      end
      chk($sformatf("wrap%0d_count", cyc), 32'(count), 32'(m_cnt));
      chk($sformatf("wrap%0d_ready", cyc), 32'(alloc_ready), 32'(m_cnt < 16));
      $display("wrap %0d: head=%0d count=%0d cv=%0b cr=%0b", cyc, h, count, commit_valid,
               commit_ready);
      do_alloc = alloc_valid && (m_cnt < 16);
      if (cdb_valid) m_done[idx] = 1'b1;
      if (exp_cv && commit_ready) begin
        m_done[h] = 1'b0;
        m_head++;
        m_cnt--;
      end
      if (do_alloc) begin
        m_done[m_tail % 16] = 1'b0;
        m_dat[m_tail % 16]  = 32'hD000_0000 + 32'(seq);
        seq++;
        m_tail++;
        m_cnt++;
      end
    end
    @(negedge clk);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
